pipe_scroller: RTL and testbench



---
 rtl/pipe_pkg.sv | 27 ++
 rtl/pipe_scroller_if.sv | 50 +++++
 rtl/lfsr16.sv | 18 +
 rtl/pipe_scroller.sv | 135 +++++++++++++
 tb/tb_pipe_scroller.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the pipe scroller block.
package pipe_pkg;

  // Every screen coordinate travels as a 10-bit unsigned value.
  localparam int COORD_W = 10;

  // Visible area of the VGA frame.
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // Game state encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  // 16-bit Fibonacci LFSR: seed and feedback taps 16,14,13,11 (bits 15,13,12,10).
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // XOR of the tapped bits, shifted in at the LSB.
  function automatic logic lfsr_fb(input logic [15:0] q);
    return ^(q & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/pipe_scroller_if.sv
// Interface bundling the game-control inputs and the pipe/status outputs of
// pipe_scroller. The score signal exists only when SCORE_COUNT_EN is defined.
// Control inputs are plain levels/pulses sampled on every rising clk edge;
// there is no valid/ready handshake: frame_tick is a one-cycle strobe and
// every cycle it is high counts as one tick.
interface pipe_scroller_if;
  import pipe_pkg::*;

  logic                frame_tick;
  logic                start;
  logic                collide;
  logic [COORD_W-1:0]  X_Edge_O1;
  logic [COORD_W-1:0]  X_Edge_O2;
  logic [COORD_W-1:0]  X_Edge_O3;
  logic [COORD_W-1:0]  X_Edge_O4;
  logic [COORD_W-1:0]  Y_Edge_O1;
  logic [COORD_W-1:0]  Y_Edge_O2;
  logic [COORD_W-1:0]  Y_Edge_O3;
  logic [COORD_W-1:0]  Y_Edge_O4;
  logic                running;
  logic                passed;
  state_t              state_dbg;
  logic [15:0]         lfsr_dbg;
`ifdef SCORE_COUNT_EN
  logic [7:0]          score;
`endif

  // Game logic / testbench side.
  modport master (
    output frame_tick, start, collide,
    input  X_Edge_O1, X_Edge_O2, X_Edge_O3, X_Edge_O4,
    input  Y_Edge_O1, Y_Edge_O2, Y_Edge_O3, Y_Edge_O4,
`ifdef SCORE_COUNT_EN
    input  score,
`endif
    input  running, passed, state_dbg, lfsr_dbg
  );

  // pipe_scroller side.
  modport slave (
    input  frame_tick, start, collide,
    output X_Edge_O1, X_Edge_O2, X_Edge_O3, X_Edge_O4,
    output Y_Edge_O1, Y_Edge_O2, Y_Edge_O3, Y_Edge_O4,
`ifdef SCORE_COUNT_EN
    output score,
`endif
    output running, passed, state_dbg, lfsr_dbg
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR. It steps every cycle outside reset so
// that player timing seeds the gap heights. It cannot reach all-zero from the
// non-zero seed.
module lfsr16
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  // Shift left, feedback into bit 0.
  always_ff @(posedge clk) begin
    if (reset) q <= LFSR_SEED;
    else       q <= {q[14:0], lfsr_fb(q)};
  end

endmodule

// File: rtl/pipe_scroller.sv
// Owns the four pipe obstacles: scrolls them left once per frame, recycles
// each pipe that leaves the left edge to the right-hand end with a random gap,
// freezes on collision and restarts on request.
// Optional feature macro: SCORE_COUNT_EN (adds an 8-bit saturating score).
module pipe_scroller
  import pipe_pkg::*;
#(
  parameter int SCROLL_STEP  = 2,
  parameter int PIPE_SPACING = 160,
  parameter int PIPE_WIDTH   = 80,
  parameter int START_OFS    = 320,
  parameter int GAP_MIN      = 40,
  parameter int GAP_RESET    = 190,
  parameter int BIRD_X       = 320
) (
  input  logic            clk,
  input  logic            reset,
  pipe_scroller_if.slave  bus
);

  localparam logic [COORD_W-1:0] STEP     = COORD_W'(SCROLL_STEP);
  localparam logic [COORD_W-1:0] WRAP_ADD = COORD_W'(4 * PIPE_SPACING - SCROLL_STEP);
  localparam logic [COORD_W-1:0] GAP_LO   = COORD_W'(GAP_MIN);
  localparam logic [COORD_W-1:0] GAP_RST  = COORD_W'(GAP_RESET);
  localparam logic [COORD_W:0]   PW11     = (COORD_W+1)'(PIPE_WIDTH);
  localparam logic [COORD_W:0]   BX11     = (COORD_W+1)'(BIRD_X);

  // Lattice position of pipe i at reset/restart.
  function automatic logic [COORD_W-1:0] home_x(input int i);
    return COORD_W'(START_OFS + i * PIPE_SPACING);
  endfunction

  logic [15:0]        lfsr_q;
  state_t             state_q, state_d;
  logic [COORD_W-1:0] x_q  [4];
  logic [COORD_W-1:0] y_q  [4];
  logic [COORD_W-1:0] x_mv [4];
  logic [COORD_W-1:0] y_mv [4];
  logic [3:0]         pass_vec;
  logic               passed_q;
  logic               do_move;
  logic               reload;

  lfsr16 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  // A collision on a tick cycle halts without moving.
  assign do_move = (state_q == RUN) && bus.frame_tick && !bus.collide;
  assign reload  = (state_q == HALT) && bus.start;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: IDLE -start-> RUN -collide-> HALT -start-> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start)   state_d = RUN;
      RUN:     if (bus.collide) state_d = HALT;
      HALT:    if (bus.start)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    bus.running   = (state_q == RUN);
    bus.state_dbg = state_q;
  end

  // Candidate move of every lane plus its pass detection at 11 bits.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      x_mv[i]     = x_q[i];
      y_mv[i]     = y_q[i];
      if (x_q[i] >= STEP) begin
        x_mv[i] = x_q[i] - STEP;
      end else begin
        x_mv[i] = x_q[i] + WRAP_ADD;
        y_mv[i] = GAP_LO + {2'b00, lfsr_q[i +: 8]};
      end
      pass_vec[i] = (({1'b0, x_q[i]} + PW11) >= BX11) &&
                    (({1'b0, x_mv[i]} + PW11) < BX11);
    end
  end

  // Pipe position/gap registers and the one-cycle passed pulse.
  always_ff @(posedge clk) begin
    if (reset || reload) begin
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= home_x(i);
        y_q[i] <= GAP_RST;
      end
      passed_q <= 1'b0;
    end else if (do_move) begin
      for (int i = 0; i < 4; i++) begin
        x_q[i] <= x_mv[i];
        y_q[i] <= y_mv[i];
      end
      passed_q <= |pass_vec;
    end else begin
      passed_q <= 1'b0;
    end
  end

`ifdef SCORE_COUNT_EN
  logic [7:0] score_q;

  // Saturating count of passed pulses, cleared on reset and restart.
  always_ff @(posedge clk) begin
    if (reset || reload)                                 score_q <= 8'd0;
    else if (do_move && (|pass_vec) && score_q != 8'hFF) score_q <= score_q + 8'd1;
  end

  assign bus.score = score_q;
`endif

  assign bus.X_Edge_O1 = x_q[0];
  assign bus.X_Edge_O2 = x_q[1];
  assign bus.X_Edge_O3 = x_q[2];
  assign bus.X_Edge_O4 = x_q[3];
  assign bus.Y_Edge_O1 = y_q[0];
  assign bus.Y_Edge_O2 = y_q[1];
  assign bus.Y_Edge_O3 = y_q[2];
  assign bus.Y_Edge_O4 = y_q[3];
  assign bus.passed    = passed_q;
  assign bus.lfsr_dbg  = lfsr_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// Directed testbench for pipe_scroller at default parameters.
// With SCROLL_STEP=2 and even start positions, pipes sit on even X only, so the
// wrap case uses X=0 -> 638 and the pass case uses X=240 -> 238.
module tb_pipe_scroller;
  import pipe_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  logic [15:0] m_lfsr;

  pipe_scroller_if bus ();

  pipe_scroller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset block.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference LFSR: taps 16,14,13,11, seed ACE1, steps every non-reset cycle.
  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // One clock; inputs driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold frame_tick high for n cycles, counting passed pulses seen.
  task automatic run_ticks(input int n, output int pc);
    pc = 0;
    bus.frame_tick = 1'b1;
    repeat (n) begin
      step();
      if (bus.passed === 1'b1) pc++;
    end
    bus.frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++; if (bus.lfsr_dbg !== 16'hACE1) begin failures++; $display("FAIL reset_lfsr got %h exp %h", bus.lfsr_dbg, 16'hACE1); end
    reset = 1'b0;
    checks++; if (bus.X_Edge_O1 !== 10'd320) begin failures++; $display("FAIL reset_x1 got %0d exp 320", bus.X_Edge_O1); end
    checks++; if (bus.X_Edge_O2 !== 10'd480) begin failures++; $display("FAIL reset_x2 got %0d exp 480", bus.X_Edge_O2); end
    checks++; if (bus.X_Edge_O3 !== 10'd640) begin failures++; $display("FAIL reset_x3 got %0d exp 640", bus.X_Edge_O3); end
    checks++; if (bus.X_Edge_O4 !== 10'd800) begin failures++; $display("FAIL reset_x4 got %0d exp 800", bus.X_Edge_O4); end
    checks++; if (bus.Y_Edge_O1 !== 10'd190 || bus.Y_Edge_O2 !== 10'd190 ||
                  bus.Y_Edge_O3 !== 10'd190 || bus.Y_Edge_O4 !== 10'd190) begin
      failures++; $display("FAIL reset_y got %0d/%0d/%0d/%0d exp 190", bus.Y_Edge_O1, bus.Y_Edge_O2, bus.Y_Edge_O3, bus.Y_Edge_O4);
    end
    checks++; if (bus.running !== 1'b0 || bus.passed !== 1'b0) begin failures++; $display("FAIL reset_flags got run=%b pass=%b exp 0/0", bus.running, bus.passed); end
    checks++; if (bus.state_dbg !== IDLE) begin failures++; $display("FAIL reset_state got %0d exp %0d", bus.state_dbg, IDLE); end
    // Ticks and collisions are ignored in IDLE.
    bus.frame_tick = 1'b1;
    bus.collide    = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    bus.collide    = 1'b0;
    step();
    checks++; if (bus.X_Edge_O1 !== 10'd320 || bus.state_dbg !== IDLE) begin failures++; $display("FAIL idle_hold got x1=%0d st=%0d exp 320/%0d", bus.X_Edge_O1, bus.state_dbg, IDLE); end
  endtask

  task automatic test_scroll();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if (bus.running !== 1'b1 || bus.state_dbg !== RUN) begin failures++; $display("FAIL start_run got run=%b st=%0d exp 1/%0d", bus.running, bus.state_dbg, RUN); end
    for (int k = 1; k <= 3; k++) begin
      bus.frame_tick = 1'b1;
      step();
      bus.frame_tick = 1'b0;
      checks++; if (bus.X_Edge_O1 !== 10'(320 - 2 * k)) begin failures++; $display("FAIL scroll_x1_%0d got %0d exp %0d", k, bus.X_Edge_O1, 320 - 2 * k); end
      step();
      checks++; if (bus.X_Edge_O1 !== 10'(320 - 2 * k)) begin failures++; $display("FAIL scroll_hold_%0d got %0d exp %0d", k, bus.X_Edge_O1, 320 - 2 * k); end
    end
    checks++; if (bus.X_Edge_O4 !== 10'd794 || bus.X_Edge_O2 !== 10'd474) begin failures++; $display("FAIL scroll_x2_x4 got %0d/%0d exp 474/794", bus.X_Edge_O2, bus.X_Edge_O4); end
  endtask

  task automatic test_pass();
    int pc;
    run_ticks(37, pc);
    checks++; if (bus.X_Edge_O1 !== 10'd240 || pc != 0) begin failures++; $display("FAIL pre_pass got x1=%0d passes=%0d exp 240/0", bus.X_Edge_O1, pc); end
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    checks++; if (bus.passed !== 1'b1 || bus.X_Edge_O1 !== 10'd238) begin failures++; $display("FAIL pass_pulse got pass=%b x1=%0d exp 1/238", bus.passed, bus.X_Edge_O1); end
`ifdef SCORE_COUNT_EN
    checks++; if (bus.score !== 8'd1) begin failures++; $display("FAIL score_one got %0d exp 1", bus.score); end
`endif
    step();
    checks++; if (bus.passed !== 1'b0) begin failures++; $display("FAIL pass_width got %b exp 0", bus.passed); end
  endtask

  task automatic test_wrap();
    int pc;
    logic [9:0] exp_y;
    run_ticks(119, pc);
    checks++; if (bus.X_Edge_O1 !== 10'd0 || bus.X_Edge_O2 !== 10'd160 || pc != 1) begin
      failures++; $display("FAIL pre_wrap got x1=%0d x2=%0d passes=%0d exp 0/160/1", bus.X_Edge_O1, bus.X_Edge_O2, pc);
    end
    exp_y = 10'd40 + {2'b00, m_lfsr[7:0]};
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    checks++; if (bus.X_Edge_O1 !== 10'd638) begin failures++; $display("FAIL wrap_x1 got %0d exp 638", bus.X_Edge_O1); end
    checks++; if (bus.X_Edge_O2 !== 10'd158 || bus.X_Edge_O3 !== 10'd318 || bus.X_Edge_O4 !== 10'd478) begin
      failures++; $display("FAIL wrap_x234 got %0d/%0d/%0d exp 158/318/478", bus.X_Edge_O2, bus.X_Edge_O3, bus.X_Edge_O4);
    end
    checks++; if (bus.Y_Edge_O1 !== exp_y) begin failures++; $display("FAIL wrap_y1 got %0d exp %0d", bus.Y_Edge_O1, exp_y); end
    checks++; if (bus.Y_Edge_O2 !== 10'd190 || bus.Y_Edge_O3 !== 10'd190 || bus.Y_Edge_O4 !== 10'd190) begin
      failures++; $display("FAIL wrap_y234 got %0d/%0d/%0d exp 190", bus.Y_Edge_O2, bus.Y_Edge_O3, bus.Y_Edge_O4);
    end
`ifdef SCORE_COUNT_EN
    checks++; if (bus.score !== 8'd2) begin failures++; $display("FAIL score_two got %0d exp 2", bus.score); end
    // 20800 ticks = 65 full lattice periods, so positions return to the same place.
    run_ticks(20800, pc);
    checks++; if (bus.score !== 8'd255) begin failures++; $display("FAIL score_sat got %0d exp 255", bus.score); end
`endif
  endtask

  task automatic test_collide();
    bus.frame_tick = 1'b1;
    bus.collide    = 1'b1;
    step();
    bus.frame_tick = 1'b0;
    bus.collide    = 1'b0;
    checks++; if (bus.state_dbg !== HALT || bus.running !== 1'b0) begin failures++; $display("FAIL collide_state got st=%0d run=%b exp %0d/0", bus.state_dbg, bus.running, HALT); end
    checks++; if (bus.X_Edge_O1 !== 10'd638 || bus.X_Edge_O2 !== 10'd158) begin failures++; $display("FAIL collide_nomove got %0d/%0d exp 638/158", bus.X_Edge_O1, bus.X_Edge_O2); end
    bus.frame_tick = 1'b1;
    step();
    step();
    bus.frame_tick = 1'b0;
    checks++; if (bus.X_Edge_O1 !== 10'd638 || bus.passed !== 1'b0) begin failures++; $display("FAIL halt_frozen got x1=%0d pass=%b exp 638/0", bus.X_Edge_O1, bus.passed); end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++; if (bus.state_dbg !== IDLE || bus.X_Edge_O1 !== 10'd320 || bus.X_Edge_O4 !== 10'd800) begin
      failures++; $display("FAIL restart got st=%0d x1=%0d x4=%0d exp %0d/320/800", bus.state_dbg, bus.X_Edge_O1, bus.X_Edge_O4, IDLE);
    end
    checks++; if (bus.Y_Edge_O1 !== 10'd190) begin failures++; $display("FAIL restart_y1 got %0d exp 190", bus.Y_Edge_O1); end
`ifdef SCORE_COUNT_EN
    checks++; if (bus.score !== 8'd0) begin failures++; $display("FAIL restart_score got %0d exp 0", bus.score); end
`endif
    checks++; if (bus.lfsr_dbg === 16'hACE1 && m_lfsr !== 16'hACE1) begin failures++; $display("FAIL restart_lfsr got %h exp %h", bus.lfsr_dbg, m_lfsr); end
  endtask

  task automatic test_reset_mid_run();
    int pc;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    run_ticks(5, pc);
    checks++; if (bus.X_Edge_O1 !== 10'd310) begin failures++; $display("FAIL midrun_x1 got %0d exp 310", bus.X_Edge_O1); end
    bus.frame_tick = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.frame_tick = 1'b0;
    checks++; if (bus.X_Edge_O1 !== 10'd320 || bus.X_Edge_O3 !== 10'd640 || bus.Y_Edge_O1 !== 10'd190) begin
      failures++; $display("FAIL midrun_reset_pos got x1=%0d x3=%0d y1=%0d exp 320/640/190", bus.X_Edge_O1, bus.X_Edge_O3, bus.Y_Edge_O1);
    end
    checks++; if (bus.state_dbg !== IDLE || bus.running !== 1'b0 || bus.passed !== 1'b0) begin
      failures++; $display("FAIL midrun_reset_state got st=%0d run=%b pass=%b exp %0d/0/0", bus.state_dbg, bus.running, bus.passed, IDLE);
    end
    checks++; if (bus.lfsr_dbg !== 16'hACE1) begin failures++; $display("FAIL midrun_reset_lfsr got %h exp %h", bus.lfsr_dbg, 16'hACE1); end
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    reset          = 1'b1;
    bus.frame_tick = 1'b0;
    bus.start      = 1'b0;
    bus.collide    = 1'b0;
    test_reset();
    test_scroll();
    test_pass();
    test_wrap();
    test_collide();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
